wb_dual_master_arbiter: RTL and testbench

Two-master, one-slave Wishbone classic arbiter. It lets the CPU's instruction-fetch port (master 0, IF) and data-memory port (master 1, MEM) share a single Wishbone slave bus to SRAM/peripherals.
- Arbitration is round-robin and registered; a grant is held for a whole transaction.
- A watchdog terminates any transaction whose slave never acks.
- It sits between `cpu_master` and the bus/SRAM controller.

---
 rtl/wb_dual_master_arbiter.sv | 164 ++++++++++++++++
 tb/tb_wb_dual_master_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_dual_master_arbiter.sv
// Two-master (IF = m0, MEM = m1), one-slave Wishbone classic arbiter with a
// registered round-robin grant and a watchdog that ends unacknowledged accesses.
module wb_dual_master_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  // IF master
  input  logic                    m0_cyc_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_we_i,
  input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_dat_i,
  input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  output logic [DATA_WIDTH-1:0]   m0_dat_o,
  // MEM master
  input  logic                    m1_cyc_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_we_i,
  input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_dat_i,
  input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  output logic [DATA_WIDTH-1:0]   m1_dat_o,
  // Slave bus
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  output logic [DATA_WIDTH/8-1:0] s_sel_o,
  input  logic                    s_ack_i,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  // Current owner, one-hot
  output logic [1:0]              grant_o
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int WDT_WIDTH = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WDT_WIDTH-1:0] WDT_LAST = WDT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [WDT_WIDTH-1:0] WDT_ONE  = WDT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    GRANT_M0 = 2'b01,
    GRANT_M1 = 2'b10
  } state_e;

  state_e               state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic [WDT_WIDTH-1:0] wdt_q, wdt_d;

  logic                  req0, req1;
  logic                  granted, ack_fwd, timeout;
  logic                  own_cyc, own_stb, own_we;
  logic [ADDR_WIDTH-1:0] own_adr;
  logic [DATA_WIDTH-1:0] own_dat;
  logic [SEL_WIDTH-1:0]  own_sel;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  // Owner's request signals; all zero while idle so the slave bus rests at 0.
  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_adr = '0;
    own_dat = '0;
    own_sel = '0;
    case (state_q)
      GRANT_M0: begin
        own_cyc = m0_cyc_i;
        own_stb = m0_stb_i;
        own_we  = m0_we_i;
        own_adr = m0_adr_i;
        own_dat = m0_dat_i;
        own_sel = m0_sel_i;
      end
      GRANT_M1: begin
        own_cyc = m1_cyc_i;
        own_stb = m1_stb_i;
        own_we  = m1_we_i;
        own_adr = m1_adr_i;
        own_dat = m1_dat_i;
        own_sel = m1_sel_i;
      end
      default: ;
    endcase
  end

  // An ack seen after the owner dropped cyc belongs to an aborted access.
  assign granted = (state_q != IDLE);
  assign ack_fwd = granted & own_cyc & s_ack_i;
  assign timeout = granted & own_cyc & ~s_ack_i & (wdt_q == WDT_LAST);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wdt_d        = wdt_q;
    case (state_q)
      IDLE: begin
        // On contention the master that did not own the bus last wins.
        if (req0 && (!req1 || last_grant_q)) begin
          state_d      = GRANT_M0;
          last_grant_d = 1'b0;
          wdt_d        = '0;
        end else if (req1) begin
          state_d      = GRANT_M1;
          last_grant_d = 1'b1;
          wdt_d        = '0;
        end
      end
      GRANT_M0, GRANT_M1: begin
        if (!own_cyc || ack_fwd || timeout) begin
          state_d = IDLE;
        end else begin
          wdt_d = wdt_q + WDT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
      wdt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wdt_q        <= wdt_d;
    end
  end

  // The timeout cycle withdraws cyc/stb so the slave sees the access end.
  assign s_cyc_o = own_cyc & ~timeout;
  assign s_stb_o = own_stb & ~timeout;
  assign s_we_o  = own_we;
  assign s_adr_o = own_adr;
  assign s_dat_o = own_dat;
  assign s_sel_o = own_sel;

  assign m0_ack_o = ack_fwd & (state_q == GRANT_M0);
  assign m0_err_o = timeout & (state_q == GRANT_M0);
  assign m0_dat_o = (state_q == GRANT_M0) ? s_dat_i : '0;

  assign m1_ack_o = ack_fwd & (state_q == GRANT_M1);
  assign m1_err_o = timeout & (state_q == GRANT_M1);
  assign m1_dat_o = (state_q == GRANT_M1) ? s_dat_i : '0;

  assign grant_o = {state_q == GRANT_M1, state_q == GRANT_M0};

endmodule

// File: tb/tb_wb_dual_master_arbiter.sv
// Bench for wb_dual_master_arbiter: two master agents fed from op queues, a
// latency-programmable slave model, and per-master expected-response queues.
module tb_wb_dual_master_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        abort;
    logic        expect_err;
  } op_t;

  typedef struct packed {
    logic        is_err;
    logic        chk_dat;
    logic [31:0] rdata;
  } exp_t;

  // Master-side drive state, one slot per master
  logic        drv_cyc[2], drv_stb[2], drv_we[2];
  logic [31:0] drv_adr[2], drv_dat[2];
  logic [3:0]  drv_sel[2];
  op_t         cur_op[2];
  logic        active[2];
  logic        ack_seen[2];
  int          gcnt[2];

  op_t         op_q[2][$];
  exp_t        exp_q[2][$];
  logic [1:0]  grant_log[$];
  logic [1:0]  prev_grant;

  int n_vec = 0;
  int n_bad = 0;

  logic        m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]  s_sel_o;
  logic [1:0]  grant_o;

  assign m0_cyc_i = drv_cyc[0];
  assign m0_stb_i = drv_stb[0];
  assign m0_we_i  = drv_we[0];
  assign m0_adr_i = drv_adr[0];
  assign m0_dat_i = drv_dat[0];
  assign m0_sel_i = drv_sel[0];
  assign m1_cyc_i = drv_cyc[1];
  assign m1_stb_i = drv_stb[1];
  assign m1_we_i  = drv_we[1];
  assign m1_adr_i = drv_adr[1];
  assign m1_dat_i = drv_dat[1];
  assign m1_sel_i = drv_sel[1];

  wb_dual_master_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
    .grant_o(grant_o)
  );

  // Slave model: acks in its slave_lat-th granted cycle; read data derived from address.
  int   scnt;
  int   slave_lat;
  logic never_ack, force_ack;

  function automatic logic [31:0] slave_rdata(input logic [31:0] adr);
    return adr ^ 32'h8000_0013;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) scnt <= 0;
    else        scnt <= (grant_o != 2'b00) ? scnt + 1 : 0;
  end

  assign s_ack_i = force_ack | (!never_ack && (grant_o != 2'b00) && (scnt == slave_lat - 1));
  assign s_dat_i = slave_rdata(s_adr_o);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic op_t mk_op(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                                input logic abort, input logic expect_err);
    op_t o;
    o.we = we; o.adr = adr; o.dat = dat; o.sel = 4'hF;
    o.abort = abort; o.expect_err = expect_err;
    return o;
  endfunction

  task automatic drive_idle(input int k);
    drv_cyc[k] = 1'b0; drv_stb[k] = 1'b0; drv_we[k] = 1'b0;
    drv_adr[k] = '0;   drv_dat[k] = '0;   drv_sel[k] = '0;
    active[k]  = 1'b0;
  endtask

  // Master agents: issue queued ops, hold until ack/err (or abort point), then release.
  initial begin
    for (int k = 0; k < 2; k++) drive_idle(k);
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (!reset) begin
          drive_idle(k);
        end else if (active[k] && (ack_seen[k] || (cur_op[k].abort && gcnt[k] == 1))) begin
          drive_idle(k);
        end else if (!active[k] && op_q[k].size() > 0) begin
          cur_op[k]  = op_q[k].pop_front();
          drv_cyc[k] = 1'b1;
          drv_stb[k] = 1'b1;
          drv_we[k]  = cur_op[k].we;
          drv_adr[k] = cur_op[k].adr;
          drv_dat[k] = cur_op[k].dat;
          drv_sel[k] = cur_op[k].sel;
          active[k]  = 1'b1;
          if (!cur_op[k].abort)
            exp_q[k].push_back('{is_err: cur_op[k].expect_err,
                                 chk_dat: !cur_op[k].we && !cur_op[k].expect_err,
                                 rdata: slave_rdata(cur_op[k].adr)});
        end
      end
    end
  end

  task automatic sb_check(input int k);
    logic        ack, err;
    logic [31:0] dat;
    exp_t        e;
    ack = (k == 1) ? m1_ack_o : m0_ack_o;
    err = (k == 1) ? m1_err_o : m0_err_o;
    dat = (k == 1) ? m1_dat_o : m0_dat_o;
    if (ack || err) begin
      if (exp_q[k].size() == 0) begin
        check($sformatf("m%0d_unexpected_resp", k), {ack, err}, 2'b00);
      end else begin
        e = exp_q[k].pop_front();
        check($sformatf("m%0d_resp_kind", k), {ack, err}, e.is_err ? 2'b01 : 2'b10);
        if (e.chk_dat) check($sformatf("m%0d_rdata", k), dat, e.rdata);
      end
    end
  endtask

  // Response scoreboard and grant monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (reset) begin
      sb_check(0);
      sb_check(1);
      if (grant_o != 2'b00 && grant_o != prev_grant) begin
        check("grant_onehot", $onehot(grant_o), 1);
        check("grant_idle_gap", prev_grant, 2'b00);
        grant_log.push_back(grant_o);
      end
    end
    prev_grant  <= grant_o;
    ack_seen[0] <= m0_ack_o | m0_err_o;
    ack_seen[1] <= m1_ack_o | m1_err_o;
    gcnt[0]     <= grant_o[0] ? gcnt[0] + 1 : 0;
    gcnt[1]     <= grant_o[1] ? gcnt[1] + 1 : 0;
  end

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((op_q[0].size() + op_q[1].size() + exp_q[0].size() + exp_q[1].size() != 0 ||
            active[0] || active[1]) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, n < budget, 1'b1);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {s_cyc_o, s_stb_o, s_we_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, grant_o}, '0);
    check({tag, "_bus"}, {s_adr_o, s_dat_o}, '0);
    check({tag, "_rdat"}, {m0_dat_o, m1_dat_o}, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no end of test, expected completion");
    $fatal(1);
  end

  initial begin
    int n_err;
    reset = 1'b0; force_ack = 1'b0; never_ack = 1'b0; slave_lat = 1;
    repeat (2) @(negedge clk);
    check_all_zero("reset_state");

    // Contention right after reset: MEM, IF, MEM, IF with an idle cycle between grants
    reset = 1'b1;
    grant_log.delete();
    for (int i = 0; i < 2; i++) begin
      op_q[0].push_back(mk_op(1'b0, 32'h8000_1000 + 32'(i * 4), '0, 1'b0, 1'b0));
      op_q[1].push_back(mk_op(1'b0, 32'h8010_2000 + 32'(i * 4), '0, 1'b0, 1'b0));
    end
    wait_idle("contention_done", 200);
    check("contention_ngrants", grant_log.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("contention_grant%0d", i),
            (i < grant_log.size()) ? grant_log[i] : 2'b00, (i % 2 == 0) ? 2'b10 : 2'b01);

    // IF alone, slave acks in its 3rd granted cycle
    slave_lat = 3;
    @(posedge clk);
    op_q[0].push_back(mk_op(1'b0, 32'h8000_0000, '0, 1'b0, 1'b0));
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("if_c%0d_m1_ack", c), m1_ack_o, 1'b0);
      if (c <= 3) check($sformatf("if_c%0d_cyc", c), s_cyc_o, 1'b1);
      if (c <= 2) check($sformatf("if_c%0d_ack", c), m0_ack_o, 1'b0);
      if (c == 3) begin
        check("if_c3_ack", m0_ack_o, 1'b1);
        check("if_c3_dat", m0_dat_o, 32'h0000_0013);
      end
      if (c == 4) check("if_c4_grant", grant_o, 2'b00);
    end
    wait_idle("if_done", 50);

    // MEM write pass-through
    slave_lat = 2;
    @(posedge clk);
    op_q[1].push_back(mk_op(1'b1, 32'h8010_0004, 32'hDEAD_BEEF, 1'b0, 1'b0));
    @(posedge clk);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check($sformatf("memw_c%0d_m0_ack", c), m0_ack_o, 1'b0);
      if (c <= 2) begin
        check($sformatf("memw_c%0d_we", c), s_we_o, 1'b1);
        check($sformatf("memw_c%0d_adr", c), s_adr_o, 32'h8010_0004);
        check($sformatf("memw_c%0d_dat", c), s_dat_o, 32'hDEAD_BEEF);
        check($sformatf("memw_c%0d_sel", c), s_sel_o, 4'hF);
        check($sformatf("memw_c%0d_m0_dat", c), m0_dat_o, 32'h0);
        check($sformatf("memw_c%0d_ack", c), m1_ack_o, (c == 2) ? 1'b1 : 1'b0);
      end
      if (c == 3) check("memw_c3_grant", grant_o, 2'b00);
    end
    wait_idle("memw_done", 50);

    // Watchdog: IF never acked, MEM waits behind it
    slave_lat = 1; never_ack = 1'b1; n_err = 0;
    @(posedge clk);
    op_q[0].push_back(mk_op(1'b0, 32'h8000_0040, '0, 1'b0, 1'b1));
    @(posedge clk);
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (m0_err_o) n_err++;
      if (c == 2) op_q[1].push_back(mk_op(1'b0, 32'h8000_0080, '0, 1'b0, 1'b0));
      if (c == 15) begin
        check("wdt_c15_err", m0_err_o, 1'b0);
        check("wdt_c15_cyc", s_cyc_o, 1'b1);
      end
      if (c == 16) begin
        check("wdt_c16_err", m0_err_o, 1'b1);
        check("wdt_c16_cyc_stb", {s_cyc_o, s_stb_o}, 2'b00);
        check("wdt_c16_grant", grant_o, 2'b01);
        never_ack = 1'b0;
      end
      if (c == 17) check("wdt_c17_grant", grant_o, 2'b00);
      if (c == 18) begin
        check("wdt_c18_grant", grant_o, 2'b10);
        check("wdt_c18_m1_ack", m1_ack_o, 1'b1);
      end
    end
    check("wdt_err_pulses", n_err, 1);
    wait_idle("wdt_done", 50);

    // Abort: MEM drops cyc in its 2nd granted cycle while the slave acks
    never_ack = 1'b1;
    @(posedge clk);
    op_q[1].push_back(mk_op(1'b0, 32'h8000_00C0, '0, 1'b1, 1'b0));
    @(posedge clk);
    @(negedge clk);
    check("abort_c1_grant", grant_o, 2'b10);
    @(posedge clk);
    #1 force_ack = 1'b1;
    @(negedge clk);
    check("abort_c2_ack_err", {m1_ack_o, m1_err_o}, 2'b00);
    check("abort_c2_cyc", s_cyc_o, 1'b0);
    @(posedge clk);
    #1 force_ack = 1'b0;
    @(negedge clk);
    check("abort_c3_grant", grant_o, 2'b00);
    wait_idle("abort_done", 50);

    // Reset mid-transaction, then contention after release
    @(posedge clk);
    op_q[0].push_back(mk_op(1'b0, 32'h8000_0100, '0, 1'b0, 1'b0));
    @(posedge clk);
    repeat (2) @(negedge clk);
    check("rst_pre_grant", grant_o, 2'b01);
    #2 reset = 1'b0;
    #1;
    check("rst_async_cyc", s_cyc_o, 1'b0);
    check("rst_async_grant", grant_o, 2'b00);
    check("rst_async_ack", {m0_ack_o, m0_err_o}, 2'b00);
    exp_q[0].delete();
    exp_q[1].delete();
    repeat (2) @(negedge clk);
    check_all_zero("rst_held");
    reset = 1'b1; never_ack = 1'b0;
    grant_log.delete();
    op_q[0].push_back(mk_op(1'b0, 32'h8000_0200, '0, 1'b0, 1'b0));
    op_q[1].push_back(mk_op(1'b0, 32'h8000_0300, '0, 1'b0, 1'b0));
    wait_idle("rst_after_done", 100);
    check("rst_first_grant", (grant_log.size() > 0) ? grant_log[0] : 2'b00, 2'b10);

    // Mixed traffic from both masters
    slave_lat = 2;
    for (int i = 0; i < 12; i++) begin
      int k;
      k = int'($urandom_range(1, 0));
      op_q[k].push_back(mk_op(1'($urandom_range(1, 0)), $urandom & 32'hFFFF_FFFC, $urandom, 1'b0, 1'b0));
    end
    wait_idle("mixed_done", 500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
